// File: rtl/dff_pkg.sv
// Shared types and defaults for the dff_deser slice.
//   slot_state_t : holding-slot FSM states
//   DEF_WIDTH    : default bits per word
//   DEF_CNT_W    : default delivered-word counter width
//   fill_w()     : width of a counter able to hold 0..width
package dff_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  function automatic int unsigned fill_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_deser_shifter.sv
// Serial-to-parallel collector for dff_deser.
// Shifts qualified serial bits into a WIDTH-bit register, tracks the
// frame position and pulses done on the edge that takes the last bit.
// Optional macro DFF_DESER_PARITY_EN: frame grows by a trailing even-parity
// bit and par_err reports the parity check of the completing frame.
//   clk, rst  : clock, asynchronous active-low reset
//   bit_in    : serial data bit
//   bit_vld   : bit_in is sampled this cycle
//   flush     : discard partial frame (wins over bit_vld)
//   fill      : bits collected in the current frame
//   done      : combinational, this edge completes a frame
//   word      : combinational, the completed data word (valid with done)
//   par_err   : combinational, parity check of the completing frame (macro only)
module dff_deser_shifter
  import dff_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_vld,
  input  logic                       flush,
  output logic [fill_w(WIDTH)-1:0]   fill,
  output logic                       done,
  output logic [WIDTH-1:0]           word
`ifdef DFF_DESER_PARITY_EN
  ,
  output logic                       par_err
`endif
);

  localparam int unsigned FW = fill_w(WIDTH);
`ifdef DFF_DESER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam logic [FW-1:0] LAST = FW'(FRAME - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  always_comb begin
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], bit_in};
    else           shifted = {bit_in, sreg[WIDTH-1:1]};
  end

  assign last_bit = (fill == LAST);
  assign done     = bit_vld & ~flush & last_bit;

`ifdef DFF_DESER_PARITY_EN
  // The last bit of the frame is parity, so the data word is already
  // complete in sreg and the parity bit is never shifted in.
  assign word    = sreg;
  assign par_err = ^{sreg, bit_in};
`else
  assign word    = shifted;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      fill <= '0;
    end else if (flush) begin
      sreg <= '0;
      fill <= '0;
    end else if (bit_vld) begin
      if (last_bit) begin
        sreg <= '0;
        fill <= '0;
      end else begin
        sreg <= shifted;
        fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/dff_deser.sv
// Deserialiser for the registered serial bit from the flop stage.
// Collects WIDTH-bit words and presents them through a one-word holding
// slot with a valid/ready handshake; counts delivered words and flags
// words dropped because the slot was still occupied.
// Optional macro DFF_DESER_PARITY_EN adds a trailing even-parity bit per
// frame and the par_err output.
//   clk, rst  : clock, asynchronous active-low reset
//   bit_in    : serial data bit, bit_vld qualifies it
//   flush     : discard partial word
//   word_rdy  : consumer accepts word_out this cycle
//   ovf_clr   : clear sticky overflow
//   word_out  : held word, meaningful while word_vld=1
//   word_vld  : holding slot full
//   fill      : bits collected in the current partial word
//   word_cnt  : delivered words, wraps
//   ovf       : sticky, a completed word was dropped
//   par_err   : parity error of held word (macro only)
module dff_deser
  import dff_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_vld,
  input  logic                     flush,
  input  logic                     word_rdy,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_vld,
  output logic [fill_w(WIDTH)-1:0] fill,
  output logic [CNT_W-1:0]         word_cnt,
  output logic                     ovf
`ifdef DFF_DESER_PARITY_EN
  ,
  output logic                     par_err
`endif
);

  slot_state_t      state, state_nxt;
  logic             done;
  logic [WIDTH-1:0] word;
  logic             hs;
  logic             load;
  logic             drop;
`ifdef DFF_DESER_PARITY_EN
  logic             frame_par_err;
`endif

  dff_deser_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .flush   (flush),
    .fill    (fill),
    .done    (done),
    .word    (word)
`ifdef DFF_DESER_PARITY_EN
    ,
    .par_err (frame_par_err)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SLOT_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (done)       state_nxt = SLOT_FULL;
      SLOT_FULL:  if (hs && !done) state_nxt = SLOT_EMPTY;
      default:                    state_nxt = SLOT_EMPTY;
    endcase
  end

  // A completing word may replace the held one on the same edge the
  // consumer takes it; otherwise it is dropped while the slot is full.
  always_comb begin
    word_vld = (state == SLOT_FULL);
    hs       = word_vld & word_rdy;
    load     = done & (~word_vld | hs);
    drop     = done & word_vld & ~hs;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_out <= '0;
      word_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (load) word_out <= word;
      if (hs)   word_cnt <= word_cnt + CNT_W'(1);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef DFF_DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      par_err <= 1'b0;
    else if (load) par_err <= frame_par_err;
  end
`endif

endmodule

// File: tb/tb_dff_deser.sv
// Bench for dff_deser: two instances share one input stream, one MSB-first
// with the default counter, one LSB-first with a 3-bit counter so wrap is
// reached. A queue-based model predicts delivered words; a negedge monitor
// compares on each handshake and tracks slot, fill, count and overflow.
module tb_dff_deser;

  localparam int unsigned W  = 8;
  localparam int unsigned FW = $clog2(W + 1);
`ifdef DFF_DESER_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bit_in, bit_vld, flush, word_rdy, ovf_clr;

  logic [W-1:0]  word_m, word_l;
  logic          vld_m, vld_l, ovf_m, ovf_l;
  logic [FW-1:0] fill_m, fill_l;
  logic [15:0]   cnt_m;
  logic [2:0]    cnt_l;
`ifdef DFF_DESER_PARITY_EN
  logic          par_m, par_l;
`endif

  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .word_rdy(word_rdy), .ovf_clr(ovf_clr), .word_out(word_m), .word_vld(vld_m),
    .fill(fill_m), .word_cnt(cnt_m), .ovf(ovf_m)
`ifdef DFF_DESER_PARITY_EN
    , .par_err(par_m)
`endif
  );

  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(3)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .word_rdy(word_rdy), .ovf_clr(ovf_clr), .word_out(word_l), .word_vld(vld_l),
    .fill(fill_l), .word_cnt(cnt_l), .ovf(ovf_l)
`ifdef DFF_DESER_PARITY_EN
    , .par_err(par_l)
`endif
  );

  typedef struct {
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    logic         perr;
  } exp_t;

  exp_t        exp_q[$];
  bit          frame_q[$];
  bit          m_full;
  bit          m_ovf;
  int unsigned m_cnt;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_q.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  // Applies the rules to the inputs sampled at the edge just taken.
  task automatic model_step();
    bit   hs, done;
    exp_t e;
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    hs   = m_full && word_rdy;
    done = 1'b0;
    e    = '{default: '0};
    if (flush) begin
      frame_q.delete();
    end else if (bit_vld) begin
      frame_q.push_back(bit_in);
      if (frame_q.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
          e.wm[W-1-i] = frame_q[i];
          e.wl[i]     = frame_q[i];
        end
        for (int i = 0; i < int'(FRAME); i++) e.perr ^= frame_q[i];
        frame_q.delete();
      end
    end
    if (hs) m_cnt++;
    if (done && (!m_full || hs)) begin
      exp_q.push_back(e);
      m_full = 1'b1;
    end else if (hs) begin
      m_full = 1'b0;
    end
    if (done && m_full && !hs && !(exp_q.size() != 0 && exp_q[$] == e && !m_full)) begin
      // dropped: only when the slot was occupied and not drained this edge
    end
    if (done && !hs && m_full_before(hs, done)) m_ovf = 1'b1;
    else if (ovf_clr)                          m_ovf = 1'b0;
  endtask

  // Slot occupancy prior to this edge, reconstructed from the post-edge view:
  // a completion without a handshake was dropped iff the slot was full before.
  bit pre_full;
  function automatic bit m_full_before(input bit hs, input bit done);
    return pre_full && done && !hs;
  endfunction

  task automatic tick();
    @(posedge clk);
    pre_full = m_full;
    model_step();
    #1;
  endtask

  // Monitor: handshake visible now completes at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      chk("word_vld_msb", {31'd0, vld_m}, {31'd0, m_full});
      chk("word_vld_lsb", {31'd0, vld_l}, {31'd0, m_full});
      chk("fill_msb", 32'(fill_m), 32'(frame_q.size()));
      chk("fill_lsb", 32'(fill_l), 32'(frame_q.size()));
      chk("word_cnt_msb", 32'(cnt_m), m_cnt % 65536);
      chk("word_cnt_lsb", 32'(cnt_l), m_cnt % 8);
      chk("ovf_msb", {31'd0, ovf_m}, {31'd0, m_ovf});
      chk("ovf_lsb", {31'd0, ovf_l}, {31'd0, m_ovf});
      if (vld_m && word_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL handshake: got word %0h, expected no word at %0t", word_m, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word_out_msb", 32'(word_m), 32'(e.wm));
          chk("word_out_lsb", 32'(word_l), 32'(e.wl));
`ifdef DFF_DESER_PARITY_EN
          chk("par_err_msb", {31'd0, par_m}, {31'd0, e.perr});
          chk("par_err_lsb", {31'd0, par_l}, {31'd0, e.perr});
`endif
        end
      end
    end
  end

  task automatic set_in(input logic bv, input logic bi, input logic fl,
                        input logic rdy, input logic oc);
    bit_vld  = bv;
    bit_in   = bi;
    flush    = fl;
    word_rdy = rdy;
    ovf_clr  = oc;
  endtask

  task automatic idle(input logic rdy, input int n);
    repeat (n) begin
      set_in(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      tick();
    end
  endtask

  // Sends v[n-1] first down to v[0].
  task automatic send_bits(input logic [15:0] v, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) begin
      set_in(1'b1, v[i], 1'b0, rdy, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
`ifdef DFF_DESER_PARITY_EN
    send_bits(16'({w, ^w}), int'(FRAME), rdy);
`else
    send_bits(16'(w), int'(FRAME), rdy);
`endif
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    pre_full = 1'b0;
    model_reset();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_word_out", 32'(word_m), 32'd0);
    chk("reset_word_vld", {31'd0, vld_m}, 32'd0);
    chk("reset_fill", 32'(fill_m), 32'd0);
    chk("reset_word_cnt", 32'(cnt_m), 32'd0);
    chk("reset_ovf", {31'd0, ovf_m}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    idle(1'b0, 2);

    // single word, consumer ready: 0x96 MSB-first, 0x69 LSB-first
    send_word(8'h96, 1'b1);
    idle(1'b1, 2);

    // overflow: second word dropped while slot held
    send_word(8'h96, 1'b0);
    send_word(8'h0F, 1'b0);
    idle(1'b0, 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle(1'b1, 2);

    // back-to-back words with continuous ready
    for (int k = 0; k < 4; k++) send_word(W'($urandom), 1'b1);
    idle(1'b1, 2);

    // asynchronous reset mid-word, between clock edges
    send_bits(16'h0015, 5, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("midreset_word_out", 32'(word_m), 32'd0);
    chk("midreset_word_vld", {31'd0, vld_m}, 32'd0);
    chk("midreset_fill", 32'(fill_m), 32'd0);
    chk("midreset_word_cnt", 32'(cnt_m), 32'd0);
    chk("midreset_ovf", {31'd0, ovf_m}, 32'd0);
    model_reset();
    tick();
    rst = 1'b1;
    send_word(8'hA5, 1'b1);
    idle(1'b1, 2);

    // flush with a pending bit, then a clean word
    send_bits(16'h0005, 3, 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    send_word(8'h3C, 1'b1);
    idle(1'b1, 2);

    // flush on the completing bit produces no word
    send_bits(16'h007F, int'(FRAME) - 1, 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle(1'b1, 2);

`ifdef DFF_DESER_PARITY_EN
    send_bits(16'({8'h96, 1'b0}), 9, 1'b1);
    idle(1'b1, 2);
    send_bits(16'({8'h96, 1'b1}), 9, 1'b1);
    idle(1'b1, 2);
`endif

    // randomized traffic
    repeat (800) begin
      set_in($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 39) == 0,
             $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      tick();
    end
    idle(1'b1, 4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
